// File: rtl/ev22_fetch.sv
// ev22_fetch -- instruction fetch and sequencing unit for the EV22 core.
//
// Fetches 24-bit instruction words from program memory over a req/ack
// handshake. It splits each word into opcode/Ri/Rj/immediate fields and
// presents them to the decoder with a valid/ready handshake. All control
// flow (JMP/JZE/JNE/JCY/BSR/RET) is resolved here against datapath flags
// sampled in the accept cycle.
//
// Build option:
//   FETCH_RSTACK_EN  defined   -> RS_DEPTH-entry circular return stack
//                    undefined -> single link register
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   run                           level: keep fetching while high
//   imem_req/imem_addr            program-memory read request / address (= PC)
//   imem_ack/imem_rdata           read-data strobe / 24-bit instruction word
//   inst_valid/inst_ready         decoder handshake
//   opcode/ri/rj/imm/pc           fields and address of presented instruction
//   flag_z/flag_w15/flag_cy       datapath flags for conditional jumps
//   rs_err                        sticky return-stack overflow/underflow
module ev22_fetch #(
  parameter int                PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int                RS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [23:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [7:0]      opcode,
  output logic [4:0]      ri,
  output logic [4:0]      rj,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  input  logic            flag_z,
  input  logic            flag_w15,
  input  logic            flag_cy,
  output logic            rs_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [23:0]     r_ir;
  logic            r_rs_err;

  logic            w_ld_ir;
  logic            w_accept;
  logic [7:0]      w_op;
  logic [PC_W-1:0] w_opnd;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_tgt;
  logic            w_push;
  logic            w_pop;
  logic            w_rs_empty;
  logic            w_rs_full;
  logic [PC_W-1:0] w_rs_top;

  assign w_op     = r_ir[23:16];
  assign w_opnd   = PC_W'(r_ir[15:0]);
  assign w_pc_inc = r_pc + PC_ONE;

  // Outputs decode straight from registered state, so reset clears them at once.
  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == S_ISSUE);
  assign opcode     = r_ir[23:16];
  assign ri         = r_ir[12:8];
  assign rj         = r_ir[4:0];
  assign imm        = r_ir[15:0];
  assign pc         = r_pc;
  assign rs_err     = r_rs_err;

  // Next-state logic; an ack outside FETCH is simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_ir     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
        else     w_state_nxt = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_ld_ir     = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (!run) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (inst_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = run ? S_FETCH : S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Branch resolution for the instruction currently held in r_ir.
  always_comb begin
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_pc_tgt = w_pc_inc;
    casez (w_op)
      8'b00100???: w_pc_tgt = w_opnd;
      8'b00101???: w_pc_tgt = flag_z    ? w_opnd : w_pc_inc;
      8'b00110???: w_pc_tgt = !flag_w15 ? w_opnd : w_pc_inc;
      8'b00111???: w_pc_tgt = flag_cy   ? w_opnd : w_pc_inc;
      8'b000111??: begin
        w_push   = 1'b1;
        w_pc_tgt = r_pc + w_opnd;
      end
      8'b01000001: begin
        w_pop = 1'b1;
        // Returning with nothing saved restarts the program.
        if (w_rs_empty) w_pc_tgt = RESET_PC;
        else            w_pc_tgt = w_rs_top + PC_ONE;
      end
      default: w_pc_tgt = w_pc_inc;
    endcase
  end

  // FSM state, program counter and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 24'h00_0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_ir)  r_ir <= imem_rdata;
      if (w_accept) r_pc <= w_pc_tgt;
    end
  end

  // Sticky error: overflow on BSR while full, underflow on RET while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_err <= 1'b0;
    end else if (w_accept && ((w_push && w_rs_full) || (w_pop && w_rs_empty))) begin
      r_rs_err <= 1'b1;
    end
  end

`ifdef FETCH_RSTACK_EN
  localparam int               RS_AW      = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam logic [RS_AW-1:0] SP_ONE     = {{(RS_AW-1){1'b0}}, 1'b1};
  localparam logic [RS_AW:0]   CNT_ONE    = {{RS_AW{1'b0}}, 1'b1};
  localparam logic [RS_AW:0]   CNT_FULL   = (RS_AW+1)'(RS_DEPTH);

  logic [PC_W-1:0] r_rs [RS_DEPTH];
  logic [RS_AW-1:0] r_sp;
  logic [RS_AW:0]   r_cnt;

  assign w_rs_empty = (r_cnt == {(RS_AW+1){1'b0}});
  assign w_rs_full  = (r_cnt == CNT_FULL);
  assign w_rs_top   = r_rs[r_sp - SP_ONE];

  // Circular stack: a push when full overwrites the oldest entry because the
  // pointer wraps (RS_DEPTH is a power of two) while the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= {RS_AW{1'b0}};
      r_cnt <= {(RS_AW+1){1'b0}};
      for (int i = 0; i < RS_DEPTH; i++) r_rs[i] <= RESET_PC;
    end else if (w_accept && w_push) begin
      r_rs[r_sp] <= r_pc;
      r_sp       <= r_sp + SP_ONE;
      if (!w_rs_full) r_cnt <= r_cnt + CNT_ONE;
    end else if (w_accept && w_pop && !w_rs_empty) begin
      r_sp  <= r_sp - SP_ONE;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end
`else
  logic [PC_W-1:0] r_link;
  logic            r_link_v;

  assign w_rs_empty = !r_link_v;
  // A lone link register is simply overwritten, so it never reports full.
  assign w_rs_full  = (RS_DEPTH == 0);
  assign w_rs_top   = r_link;

  // Link register: BSR overwrites it; RET reads it without consuming it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link   <= RESET_PC;
      r_link_v <= 1'b0;
    end else if (w_accept && w_push) begin
      r_link   <= r_pc;
      r_link_v <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ev22_fetch.sv
// Directed testbench for ev22_fetch with a behavioural program memory.
module tb_ev22_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [23:0] imem_rdata = 24'h00_0000;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [7:0]  opcode;
  logic [4:0]  ri;
  logic [4:0]  rj;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        flag_z = 1'b0;
  logic        flag_w15 = 1'b0;
  logic        flag_cy = 1'b0;
  logic        rs_err;

  logic [23:0] mem [0:65535];
  logic        rand_ack = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;

  ev22_fetch #(.PC_W(16), .RESET_PC(16'h0000), .RS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .opcode(opcode), .ri(ri), .rj(rj), .imm(imm), .pc(pc),
    .flag_z(flag_z), .flag_w15(flag_w15), .flag_cy(flag_cy),
    .rs_err(rs_err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks in the first FETCH cycle, or random noise.
  always @(negedge clk) begin
    if (rand_ack) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = 24'($urandom);
    end else begin
      imem_ack   = imem_req;
      imem_rdata = mem[imem_addr];
    end
  end

  function automatic logic [23:0] plain(input logic [15:0] a);
    plain = {4'h6, a[3:0], 3'b000, a[4:0], 3'b000, ~a[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_issue(input logic [15:0] epc, input logic [23:0] w, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!inst_valid && c < 40);
    chk("valid", 32'(inst_valid), 32'd1);
    chk("pc", 32'(pc), 32'(epc));
    chk("opcode", 32'(opcode), 32'(w[23:16]));
    chk("ri", 32'(ri), 32'(w[12:8]));
    chk("rj", 32'(rj), 32'(w[4:0]));
    chk("imm", 32'(imm), 32'(w[15:0]));
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = plain(16'(a));
    mem[16'h0005] = 24'h20_0040;
    mem[16'h0040] = 24'h28_0010;
    mem[16'h0041] = 24'h28_0010;
    mem[16'h0010] = 24'h1C_0005;
    mem[16'h0015] = 24'h41_0000;
    mem[16'h0012] = 24'h30_0020;
    mem[16'h0013] = 24'h38_0030;
    mem[16'h0030] = 24'h30_0050;
    mem[16'h0051] = 24'h20_FFFF;
    mem[16'h0060] = 24'h1C_0010;
    mem[16'h0070] = 24'h1C_0010;
    mem[16'h0080] = 24'h41_0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fields", {opcode, ri, rj, imm[13:0]}, 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_err", 32'(rs_err), 32'd0);

    // Sequential plain ops, one every 2 cycles
    rst_n = 1'b1;
    run = 1'b1;
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_issue(16'(k), plain(16'(k)), cyc);
      chk("cycles", 32'(cyc), 32'd2);
    end

    // JMP and JZE both ways
    expect_issue(16'h0004, plain(16'h0004), cyc);
    expect_issue(16'h0005, 24'h20_0040, cyc);
    @(negedge clk);
    chk("jmp_req", 32'(imem_req), 32'd1);
    chk("jmp_addr", 32'(imem_addr), 32'h0040);
    expect_issue(16'h0040, 24'h28_0010, cyc);
    expect_issue(16'h0041, 24'h28_0010, cyc);
    flag_z = 1'b1;
    expect_issue(16'h0010, 24'h1C_0005, cyc);
    flag_z = 1'b0;

    // BSR / RET with the link
    expect_issue(16'h0015, 24'h41_0000, cyc);
    expect_issue(16'h0011, plain(16'h0011), cyc);
    chk("err_after_ret", 32'(rs_err), 32'd0);

    // JNE not taken, JCY taken, JNE taken
    expect_issue(16'h0012, 24'h30_0020, cyc);
    flag_w15 = 1'b1;
    expect_issue(16'h0013, 24'h38_0030, cyc);
    flag_w15 = 1'b0;
    flag_cy = 1'b1;
    expect_issue(16'h0030, 24'h30_0050, cyc);
    flag_cy = 1'b0;
    expect_issue(16'h0050, plain(16'h0050), cyc);

    // Consumer stall with noisy ack
    inst_ready = 1'b0;
    rand_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", 32'(pc), 32'h0050);
      chk("stall_op", 32'(opcode), 32'h60);
      chk("stall_imm", 32'(imm), 32'(plain(16'h0050) & 24'h00_FFFF));
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    inst_ready = 1'b1;
    rand_ack = 1'b0;

    // PC wrap at 0xFFFF
    expect_issue(16'h0051, 24'h20_FFFF, cyc);
    expect_issue(16'hFFFF, plain(16'hFFFF), cyc);
    @(negedge clk);
    chk("wrap_req", 32'(imem_req), 32'd1);
    chk("wrap_addr", 32'(imem_addr), 32'h0000);
    expect_issue(16'h0000, plain(16'h0000), cyc);

    // Asynchronous reset during a pending read
    @(negedge clk);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_op", 32'(opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RET with nothing saved -> RESET_PC, sticky error
    mem[16'h0002] = 24'h41_0000;
    expect_issue(16'h0000, plain(16'h0000), cyc);
    mem[16'h0000] = 24'h20_0060;
    expect_issue(16'h0001, plain(16'h0001), cyc);
    expect_issue(16'h0002, 24'h41_0000, cyc);
    chk("err_before_unf", 32'(rs_err), 32'd0);
    expect_issue(16'h0000, 24'h20_0060, cyc);
    chk("err_unf", 32'(rs_err), 32'd1);

    // Second BSR overwrites/stacks over the first; RET returns to latest
    expect_issue(16'h0060, 24'h1C_0010, cyc);
    expect_issue(16'h0070, 24'h1C_0010, cyc);
    expect_issue(16'h0080, 24'h41_0000, cyc);
    expect_issue(16'h0071, plain(16'h0071), cyc);
    chk("err_sticky", 32'(rs_err), 32'd1);

`ifdef FETCH_RSTACK_EN
    // 5 nested BSRs into a 4-deep stack, then 5 RETs
    @(negedge clk);
    rst_n = 1'b0;
    mem[16'h0000] = 24'h20_0100;
    for (int k = 0; k < 5; k++) mem[16'h0100 + 16'(k * 16)] = 24'h1C_0010;
    mem[16'h0150] = 24'h41_0000;
    mem[16'h0141] = 24'h41_0000;
    mem[16'h0131] = 24'h41_0000;
    mem[16'h0121] = 24'h41_0000;
    mem[16'h0111] = 24'h41_0000;
    @(negedge clk);
    rst_n = 1'b1;
    expect_issue(16'h0000, 24'h20_0100, cyc);
    for (int k = 0; k < 5; k++) begin
      expect_issue(16'h0100 + 16'(k * 16), 24'h1C_0010, cyc);
      chk("stk_err_pre", 32'(rs_err), 32'd0);
    end
    expect_issue(16'h0150, 24'h41_0000, cyc);
    chk("stk_ovf", 32'(rs_err), 32'd1);
    expect_issue(16'h0141, 24'h41_0000, cyc);
    expect_issue(16'h0131, 24'h41_0000, cyc);
    expect_issue(16'h0121, 24'h41_0000, cyc);
    expect_issue(16'h0111, 24'h41_0000, cyc);
    expect_issue(16'h0000, 24'h20_0100, cyc);
    chk("stk_err_end", 32'(rs_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
